// File: rtl/hifp_lmem_pkg.sv
// Shared constants for the hifp local-memory arbiter: owner encoding and default widths.
package hifp_lmem_pkg;

  typedef enum logic {
    OWN_LD = 1'b0,
    OWN_ST = 1'b1
  } owner_e;

  localparam int unsigned DEF_DATA_W   = 512;
  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_BURST_W  = 5;
  localparam int unsigned DEF_RD_DEPTH = 8;
  localparam int unsigned DEF_WR_DEPTH = 8;

endpackage

// File: rtl/hifp_owner_fifo.sv
// Small synchronous FIFO recording which master owns each outstanding response.
module hifp_owner_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A push is refused whenever full, even if a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hifp_lmem_arbiter.sv
// Round-robin arbiter sharing one local-memory bank port between the hifp load and store
// masters, with write-burst locking and in-order response routing.
module hifp_lmem_arbiter
  import hifp_lmem_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned BURST_W  = DEF_BURST_W,
  parameter int unsigned RD_DEPTH = DEF_RD_DEPTH,
  parameter int unsigned WR_DEPTH = DEF_WR_DEPTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   ld_address,
  input  logic                ld_read,
  input  logic                ld_write,
  input  logic [DATA_W-1:0]   ld_writedata,
  input  logic [DATA_W/8-1:0] ld_byteenable,
  input  logic [BURST_W-1:0]  ld_burstcount,
  output logic                ld_waitrequest,
  output logic [DATA_W-1:0]   ld_readdata,
  output logic                ld_readdatavalid,
  output logic                ld_writeack,
  input  logic [ADDR_W-1:0]   st_address,
  input  logic                st_read,
  input  logic                st_write,
  input  logic [DATA_W-1:0]   st_writedata,
  input  logic [DATA_W/8-1:0] st_byteenable,
  input  logic [BURST_W-1:0]  st_burstcount,
  output logic                st_waitrequest,
  output logic [DATA_W-1:0]   st_readdata,
  output logic                st_readdatavalid,
  output logic                st_writeack,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [BURST_W-1:0]  mem_burstcount,
  input  logic                mem_waitrequest,
  input  logic [DATA_W-1:0]   mem_readdata,
  input  logic                mem_readdatavalid,
  input  logic                mem_writeack,
  output logic                err
);

  localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

  owner_e             gnt;
  owner_e             rr;
  owner_e             lock_owner;
  owner_e             rd_head_own;
  owner_e             wr_head_own;
  logic               lock;
  logic [BURST_W-1:0] beats_left;
  logic [BURST_W-1:0] rd_beats;
  logic [BURST_W-1:0] bc_raw;
  logic [BURST_W-1:0] bc_eff;
  logic [BURST_W-1:0] rd_head_bc;
  logic [BURST_W:0]   rd_head;
  logic               wr_head;
  logic               hold_q;
  logic               hold;
  logic               req_ld;
  logic               req_st;
  logic               g_read;
  logic               g_write;
  logic               g_wait;
  logic               stall;
  logic               rd_acc;
  logic               wr_acc;
  logic               wr_last;
  logic               rd_full;
  logic               rd_empty;
  logic               wr_full;
  logic               wr_empty;
  logic               rd_resp;
  logic               wr_resp;
  logic               rd_fwd;
  logic               wr_fwd;
  logic               rd_pop;

  // Everything stays idle during reset and for one cycle after it.
  assign hold   = reset | hold_q;
  assign req_ld = ld_read | ld_write;
  assign req_st = st_read | st_write;

  always_comb begin
    if (lock)                  gnt = lock_owner;
    else if (req_ld && req_st) gnt = rr;
    else if (req_st)           gnt = OWN_ST;
    else                       gnt = OWN_LD;
  end

  assign g_read         = (gnt == OWN_ST) ? st_read       : ld_read;
  assign g_write        = (gnt == OWN_ST) ? st_write      : ld_write;
  assign bc_raw         = (gnt == OWN_ST) ? st_burstcount : ld_burstcount;
  assign mem_address    = (gnt == OWN_ST) ? st_address    : ld_address;
  assign mem_writedata  = (gnt == OWN_ST) ? st_writedata  : ld_writedata;
  assign mem_byteenable = (gnt == OWN_ST) ? st_byteenable : ld_byteenable;
  assign bc_eff         = (bc_raw == '0) ? ONE : bc_raw;
  assign mem_burstcount = bc_eff;

  assign stall     = (g_read & rd_full) | (g_write & wr_full);
  assign mem_read  = g_read & ~stall & ~hold;
  assign mem_write = g_write & ~stall & ~hold;
  assign g_wait    = mem_waitrequest | stall | hold;

  assign ld_waitrequest = (gnt == OWN_LD) ? g_wait : 1'b1;
  assign st_waitrequest = (gnt == OWN_ST) ? g_wait : 1'b1;

  assign rd_acc  = mem_read & ~mem_waitrequest;
  assign wr_acc  = mem_write & ~mem_waitrequest;
  assign wr_last = wr_acc & (lock ? (beats_left == ONE) : (bc_eff == ONE));

  assign rd_head_own = owner_e'(rd_head[BURST_W]);
  assign rd_head_bc  = rd_head[BURST_W-1:0];
  assign wr_head_own = owner_e'(wr_head);

  assign rd_resp = mem_readdatavalid & ~hold;
  assign wr_resp = mem_writeack & ~hold;
  assign rd_fwd  = rd_resp & ~rd_empty;
  assign wr_fwd  = wr_resp & ~wr_empty;
  assign rd_pop  = rd_fwd & ((rd_beats + ONE) == rd_head_bc);

  assign ld_readdata      = mem_readdata;
  assign st_readdata      = mem_readdata;
  assign ld_readdatavalid = rd_fwd & (rd_head_own == OWN_LD);
  assign st_readdatavalid = rd_fwd & (rd_head_own == OWN_ST);
  assign ld_writeack      = wr_fwd & (wr_head_own == OWN_LD);
  assign st_writeack      = wr_fwd & (wr_head_own == OWN_ST);

  hifp_owner_fifo #(
    .WIDTH (1 + BURST_W),
    .DEPTH (RD_DEPTH)
  ) u_rd_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_acc),
    .push_data ({logic'(gnt), bc_eff}),
    .pop       (rd_pop),
    .head      (rd_head),
    .full      (rd_full),
    .empty     (rd_empty)
  );

  hifp_owner_fifo #(
    .WIDTH (1),
    .DEPTH (WR_DEPTH)
  ) u_wr_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_acc),
    .push_data (logic'(gnt)),
    .pop       (wr_fwd),
    .head      (wr_head),
    .full      (wr_full),
    .empty     (wr_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q     <= 1'b1;
      rr         <= OWN_LD;
      lock       <= 1'b0;
      lock_owner <= OWN_LD;
      beats_left <= '0;
      rd_beats   <= '0;
      err        <= 1'b0;
    end else begin
      hold_q <= 1'b0;
      if (rd_acc || wr_last) rr <= (gnt == OWN_LD) ? OWN_ST : OWN_LD;
      if (wr_acc) begin
        if (!lock) begin
          if (bc_eff != ONE) begin
            lock       <= 1'b1;
            lock_owner <= gnt;
            beats_left <= bc_eff - ONE;
          end
        end else begin
          beats_left <= beats_left - ONE;
          if (beats_left == ONE) lock <= 1'b0;
        end
      end
      if (rd_fwd) rd_beats <= rd_pop ? '0 : rd_beats + ONE;
      if ((rd_resp && rd_empty) || (wr_resp && wr_empty) ||
          ((rd_acc || wr_acc) && bc_raw == '0))
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hifp_lmem_arbiter.sv
// Randomized self-checking bench for hifp_lmem_arbiter against a queue-based reference model.
module tb_hifp_lmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int BW = 5;
  localparam int RDD = 8;
  localparam int WRD = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] ld_address, st_address, mem_address;
  logic          ld_read, ld_write, st_read, st_write, mem_read, mem_write;
  logic [DW-1:0] ld_writedata, st_writedata, mem_writedata;
  logic [DW/8-1:0] ld_byteenable, st_byteenable, mem_byteenable;
  logic [BW-1:0] ld_burstcount, st_burstcount, mem_burstcount;
  logic          ld_waitrequest, st_waitrequest, mem_waitrequest;
  logic [DW-1:0] ld_readdata, st_readdata, mem_readdata;
  logic          ld_readdatavalid, st_readdatavalid, mem_readdatavalid;
  logic          ld_writeack, st_writeack, mem_writeack;
  logic          err;

  always #5 clock = ~clock;

  hifp_lmem_arbiter #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .BURST_W  (BW),
    .RD_DEPTH (RDD),
    .WR_DEPTH (WRD)
  ) dut (
    .clock (clock), .reset (reset),
    .ld_address (ld_address), .ld_read (ld_read), .ld_write (ld_write),
    .ld_writedata (ld_writedata), .ld_byteenable (ld_byteenable), .ld_burstcount (ld_burstcount),
    .ld_waitrequest (ld_waitrequest), .ld_readdata (ld_readdata),
    .ld_readdatavalid (ld_readdatavalid), .ld_writeack (ld_writeack),
    .st_address (st_address), .st_read (st_read), .st_write (st_write),
    .st_writedata (st_writedata), .st_byteenable (st_byteenable), .st_burstcount (st_burstcount),
    .st_waitrequest (st_waitrequest), .st_readdata (st_readdata),
    .st_readdatavalid (st_readdatavalid), .st_writeack (st_writeack),
    .mem_address (mem_address), .mem_read (mem_read), .mem_write (mem_write),
    .mem_writedata (mem_writedata), .mem_byteenable (mem_byteenable), .mem_burstcount (mem_burstcount),
    .mem_waitrequest (mem_waitrequest), .mem_readdata (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid), .mem_writeack (mem_writeack),
    .err (err)
  );

  typedef struct { bit own; int left; } rd_ent_t;

  rd_ent_t rdq[$];
  bit      wrq[$];
  bit      m_rr, m_lock_own, m_err, m_post_rst;
  int      m_lock_left;
  int      errors = 0;
  int      checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    ld_read = 0; ld_write = 0; st_read = 0; st_write = 0;
    ld_burstcount = 1; st_burstcount = 1;
    mem_waitrequest = 0; mem_readdatavalid = 0; mem_writeack = 0;
  endtask

  // Compare the current cycle against the model, advance the model, then move past the edge.
  task automatic step();
    bit hold, rq0, rq1, g, gr, gw, stl, e_rd, e_wr, a_rd, a_wr, rv, wa, last;
    int raw, bc;
    #1;
    hold = reset || m_post_rst;
    rq0  = ld_read || ld_write;
    rq1  = st_read || st_write;
    if (m_lock_left > 0)  g = m_lock_own;
    else if (rq0 && rq1)  g = m_rr;
    else                  g = rq1;
    gr   = g ? st_read : ld_read;
    gw   = g ? st_write : ld_write;
    raw  = g ? int'(st_burstcount) : int'(ld_burstcount);
    bc   = (raw == 0) ? 1 : raw;
    stl  = (gr && rdq.size() == RDD) || (gw && wrq.size() == WRD);
    e_rd = gr && !stl && !hold;
    e_wr = gw && !stl && !hold;
    chk("mem_read", mem_read, e_rd);
    chk("mem_write", mem_write, e_wr);
    chk("ld_waitrequest", ld_waitrequest, g ? 1'b1 : (mem_waitrequest || stl || hold));
    chk("st_waitrequest", st_waitrequest, g ? (mem_waitrequest || stl || hold) : 1'b1);
    if (e_rd || e_wr) begin
      chk("mem_address", mem_address, g ? st_address : ld_address);
      chk("mem_burstcount", mem_burstcount, bc);
    end
    if (e_wr) begin
      chk("mem_writedata", mem_writedata, g ? st_writedata : ld_writedata);
      chk("mem_byteenable", mem_byteenable, g ? st_byteenable : ld_byteenable);
    end
    rv = mem_readdatavalid && !hold;
    wa = mem_writeack && !hold;
    chk("ld_readdatavalid", ld_readdatavalid, rv && rdq.size() > 0 && rdq[0].own == 0);
    chk("st_readdatavalid", st_readdatavalid, rv && rdq.size() > 0 && rdq[0].own == 1);
    chk("ld_writeack", ld_writeack, wa && wrq.size() > 0 && wrq[0] == 0);
    chk("st_writeack", st_writeack, wa && wrq.size() > 0 && wrq[0] == 1);
    if (rv) begin
      chk("ld_readdata", ld_readdata, mem_readdata);
      chk("st_readdata", st_readdata, mem_readdata);
    end
    chk("err", err, m_err);

    a_rd = e_rd && !mem_waitrequest;
    a_wr = e_wr && !mem_waitrequest;
    if (rv) begin
      if (rdq.size() == 0) m_err = 1;
      else begin
        rdq[0].left--;
        if (rdq[0].left == 0) void'(rdq.pop_front());
      end
    end
    if (wa) begin
      if (wrq.size() == 0) m_err = 1;
      else void'(wrq.pop_front());
    end
    if ((a_rd || a_wr) && raw == 0) m_err = 1;
    if (a_rd) rdq.push_back('{own: g, left: bc});
    last = 0;
    if (a_wr) begin
      wrq.push_back(g);
      if (m_lock_left == 0) begin
        if (bc > 1) begin m_lock_left = bc - 1; m_lock_own = g; end
        else last = 1;
      end else begin
        m_lock_left--;
        last = (m_lock_left == 0);
      end
    end
    if (a_rd || last) m_rr = !g;
    if (reset) begin
      rdq.delete(); wrq.delete();
      m_rr = 0; m_lock_left = 0; m_err = 0;
    end
    m_post_rst = reset;
    @(posedge clock);
    #1;
  endtask

  task automatic rand_inputs();
    int r;
    r = $urandom_range(0, 9);
    ld_read  = (r < 4);
    ld_write = (r == 4);
    r = $urandom_range(0, 9);
    st_write = (r < 4);
    st_read  = (r == 4);
    ld_burstcount = BW'($urandom_range(1, 4));
    st_burstcount = BW'($urandom_range(1, 4));
    ld_address = AW'($urandom); st_address = AW'($urandom);
    ld_writedata = $urandom; st_writedata = $urandom;
    ld_byteenable = 4'($urandom); st_byteenable = 4'($urandom);
    mem_readdata = $urandom;
    mem_waitrequest   = ($urandom_range(0, 3) == 0);
    mem_readdatavalid = (rdq.size() > 0) && ($urandom_range(0, 2) != 0);
    mem_writeack      = (wrq.size() > 0) && ($urandom_range(0, 2) == 0);
  endtask

  task automatic do_reset(input int n);
    idle();
    reset = 1;
    repeat (n) step();
    reset = 0;
  endtask

  initial begin
    ld_address = '0; st_address = '0; ld_writedata = '0; st_writedata = '0;
    ld_byteenable = '1; st_byteenable = '1; mem_readdata = '0;
    m_rr = 0; m_lock_own = 0; m_lock_left = 0; m_err = 0; m_post_rst = 1;
    idle();
    reset = 1;
    @(posedge clock);
    #1;
    do_reset(2);

    // Both masters contending from reset: model expects ld, st, ld, st.
    ld_read = 1; st_write = 1;
    repeat (6) step();

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    // Store burst of 3 holds the grant while ld waits.
    do_reset(1);
    step();
    st_write = 1; st_burstcount = 3; ld_read = 1;
    repeat (5) step();

    // Eight reads withheld: the ninth stalls until one read retires.
    do_reset(1);
    idle();
    ld_read = 1;
    repeat (11) step();
    mem_readdatavalid = 1;
    step();
    mem_readdatavalid = 0;
    repeat (3) step();

    // Reset with reads outstanding, then normal grant after the hold cycle.
    reset = 1;
    step();
    reset = 0;
    repeat (4) step();

    // Spurious read data with an empty FIFO raises a sticky error.
    do_reset(1);
    mem_readdatavalid = 1;
    repeat (2) step();
    mem_readdatavalid = 0;
    repeat (4) step();

    // Spurious write ack raises the error too.
    do_reset(1);
    step();
    mem_writeack = 1;
    step();
    mem_writeack = 0;
    repeat (3) step();

    // A zero burstcount is flagged and forwarded as a single beat.
    do_reset(1);
    step();
    ld_write = 1; ld_burstcount = 0;
    step();
    idle();
    step();
    mem_writeack = 1;
    step();
    idle();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
